// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline slice.
// Holds the branch-predictor counter encoding and default sizes.
package rv32i_types;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam int BP_IDX_BITS_DEFAULT  = 6;
  localparam int BP_CNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/branch_predictor_if.sv
// Predict (IF side) and update (EX side) bundle of the branch predictor.
// master = pipeline, slave = predictor.
interface branch_predictor_if #(
  parameter int CNT_WIDTH = rv32i_types::BP_CNT_WIDTH_DEFAULT
);
  logic                 fetch_req;
  logic [31:0]          fetch_pc;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic                 upd_valid;
  logic [31:0]          upd_pc;
  logic                 upd_taken;
  logic                 upd_pred_taken;
  logic [31:0]          upd_target;
  logic [CNT_WIDTH-1:0] mispredict_cnt;

  modport master (
    output fetch_req, fetch_pc,
    output upd_valid, upd_pc, upd_taken,
    output upd_pred_taken, upd_target,
    input  pred_valid, pred_taken, pred_target,
    input  mispredict_cnt
  );

  modport slave (
    input  fetch_req, fetch_pc,
    input  upd_valid, upd_pc, upd_taken,
    input  upd_pred_taken, upd_target,
    output pred_valid, pred_taken, pred_target,
    output mispredict_cnt
  );
endinterface

// File: rtl/bp_ctr_update.sv
// 2-bit saturating counter next-state.
// Shared by the table write path and the same-index bypass.
module bp_ctr_update
  import rv32i_types::*;
(
  input  bp_ctr_t cur_i,
  input  logic    taken_i,
  output bp_ctr_t nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    unique case (cur_i)
      SNT: nxt_o = taken_i ? WNT : SNT;
      WNT: nxt_o = taken_i ? WT  : SNT;
      WT:  nxt_o = taken_i ? ST  : WNT;
      ST:  nxt_o = taken_i ? ST  : WT;
      default: nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// PC-indexed 2-bit counter branch predictor with write-first bypass.
// Optional BTB (tag + target per entry) enabled by defining BP_BTB_EN.
module branch_predictor
  import rv32i_types::*;
#(
  parameter int IDX_BITS  = BP_IDX_BITS_DEFAULT,
  parameter int CNT_WIDTH = BP_CNT_WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int N = 1 << IDX_BITS;

  logic [IDX_BITS-1:0]  f_idx, u_idx;
  bp_ctr_t              ctr_q [N];
  bp_ctr_t              u_nxt, f_ctr;
  logic                 same_idx;
  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [31:0]          pred_target_q, pred_target_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign f_idx    = bp.fetch_pc[IDX_BITS+1:2];
  assign u_idx    = bp.upd_pc[IDX_BITS+1:2];
  assign same_idx = bp.upd_valid && (u_idx == f_idx);

  bp_ctr_update u_ctr_update (
    .cur_i   (ctr_q[u_idx]),
    .taken_i (bp.upd_taken),
    .nxt_o   (u_nxt)
  );

  assign f_ctr = same_idx ? u_nxt : ctr_q[f_idx];

`ifdef BP_BTB_EN
  localparam int TAG_W = 30 - IDX_BITS;

  logic             btb_v_q   [N];
  logic [TAG_W-1:0] btb_tag_q [N];
  logic [31:0]      btb_tgt_q [N];
  logic             btb_wr;
  logic             e_v, hit;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_tgt;
  logic             unused;

  assign btb_wr = bp.upd_valid && bp.upd_taken;
  assign unused = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

  // Entry seen by fetch reflects a same-cycle taken write.
  always_comb begin
    e_v   = btb_v_q[f_idx];
    e_tag = btb_tag_q[f_idx];
    e_tgt = btb_tgt_q[f_idx];
    if (btb_wr && u_idx == f_idx) begin
      e_v   = 1'b1;
      e_tag = bp.upd_pc[31:IDX_BITS+2];
      e_tgt = bp.upd_target;
    end
  end

  assign hit = e_v && (e_tag == bp.fetch_pc[31:IDX_BITS+2]);

  always_comb begin
    pred_taken_d  = bp.fetch_req && hit && f_ctr[1];
    pred_target_d = (bp.fetch_req && hit) ? e_tgt : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) btb_v_q[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_v_q[u_idx]   <= 1'b1;
      btb_tag_q[u_idx] <= bp.upd_pc[31:IDX_BITS+2];
      btb_tgt_q[u_idx] <= bp.upd_target;
    end
  end
`else
  logic unused;

  assign unused = ^{bp.fetch_pc[1:0], bp.fetch_pc[31:IDX_BITS+2],
                    bp.upd_pc[1:0], bp.upd_pc[31:IDX_BITS+2],
                    bp.upd_target};

  always_comb begin
    pred_taken_d  = bp.fetch_req && f_ctr[1];
    pred_target_d = 32'b0;
  end
`endif

  assign pred_valid_d = bp.fetch_req;

  always_comb begin
    cnt_d = cnt_q;
    if (bp.upd_valid && (bp.upd_taken != bp.upd_pred_taken)
        && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= WNT;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'b0;
      cnt_q         <= '0;
    end else begin
      if (bp.upd_valid) ctr_q[u_idx] <= u_nxt;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bp.pred_valid     = pred_valid_q;
  assign bp.pred_taken     = pred_taken_q;
  assign bp.pred_target    = pred_target_q;
  assign bp.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default and BP_BTB_EN builds).
// A second instance with a 2-bit counter exercises saturation.
module tb_branch_predictor;

`ifdef BP_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.CNT_WIDTH(32)) bp ();
  branch_predictor_if #(.CNT_WIDTH(2))  bp2 ();

  assign bp2.fetch_req      = bp.fetch_req;
  assign bp2.fetch_pc       = bp.fetch_pc;
  assign bp2.upd_valid      = bp.upd_valid;
  assign bp2.upd_pc         = bp.upd_pc;
  assign bp2.upd_taken      = bp.upd_taken;
  assign bp2.upd_pred_taken = bp.upd_pred_taken;
  assign bp2.upd_target     = bp.upd_target;

  branch_predictor #(.IDX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  branch_predictor #(.IDX_BITS(6), .CNT_WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bp  (bp2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp.fetch_req      = 1'b0;
    bp.fetch_pc       = 32'h0;
    bp.upd_valid      = 1'b0;
    bp.upd_pc         = 32'h0;
    bp.upd_taken      = 1'b0;
    bp.upd_pred_taken = 1'b0;
    bp.upd_target     = 32'h0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic t,
                         input logic pt, input logic [31:0] tgt);
    bp.upd_valid      = 1'b1;
    bp.upd_pc         = pc;
    bp.upd_taken      = t;
    bp.upd_pred_taken = pt;
    bp.upd_target     = tgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t,
                     input logic pt, input logic [31:0] tgt);
    idle();
    set_upd(pc, t, pt, tgt);
    step();
    idle();
  endtask

  task automatic fetch(input logic [31:0] pc);
    idle();
    bp.fetch_req = 1'b1;
    bp.fetch_pc  = pc;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    do_reset();
    chk("rst_valid", {31'b0, bp.pred_valid}, 32'h0);
    chk("rst_taken", {31'b0, bp.pred_taken}, 32'h0);
    chk("rst_target", bp.pred_target, 32'h0);
    chk("rst_cnt", bp.mispredict_cnt, 32'h0);

    // 1: fresh entry is WNT
    fetch(32'h100);
    chk("t1_valid", {31'b0, bp.pred_valid}, 32'h1);
    chk("t1_taken", {31'b0, bp.pred_taken}, 32'h0);
    chk("t1_target", bp.pred_target, 32'h0);

    // 2: train to ST, then back off to WT
    repeat (3) upd(32'h100, 1'b1, 1'b1, 32'h180);
    fetch(32'h100);
    chk("t2_st_taken", {31'b0, bp.pred_taken}, 32'h1);
    chk("t2_st_target", bp.pred_target, BTB ? 32'h180 : 32'h0);
    upd(32'h100, 1'b0, 1'b0, 32'h180);
    fetch(32'h100);
    chk("t2_wt_taken", {31'b0, bp.pred_taken}, 32'h1);

    // 3: saturate at SNT, one taken -> WNT
    repeat (5) upd(32'h40, 1'b0, 1'b0, 32'h80);
    fetch(32'h40);
    chk("t3_snt_taken", {31'b0, bp.pred_taken}, 32'h0);
    upd(32'h40, 1'b1, 1'b1, 32'h80);
    fetch(32'h40);
    chk("t3_wnt_taken", {31'b0, bp.pred_taken}, 32'h0);
    chk("t3_wnt_target", bp.pred_target, BTB ? 32'h80 : 32'h0);
    chk("t3_cnt", bp.mispredict_cnt, 32'h0);

    // 4: same-cycle update and fetch, same index
    do_reset();
    idle();
    set_upd(32'h200, 1'b1, 1'b1, 32'h300);
    bp.fetch_req = 1'b1;
    bp.fetch_pc  = 32'h200;
    step();
    idle();
    chk("t4_byp_valid", {31'b0, bp.pred_valid}, 32'h1);
    chk("t4_byp_taken", {31'b0, bp.pred_taken}, 32'h1);
    chk("t4_byp_target", bp.pred_target, BTB ? 32'h300 : 32'h0);
    fetch(32'h200);
    chk("t4_after_taken", {31'b0, bp.pred_taken}, 32'h1);

    // 5: mispredict counting and saturation
    repeat (3) upd(32'h10, 1'b1, 1'b0, 32'h20);
    chk("t5_cnt3", bp.mispredict_cnt, 32'd3);
    chk("t5_cnt3_w2", {30'b0, bp2.mispredict_cnt}, 32'd3);
    repeat (2) upd(32'h10, 1'b0, 1'b1, 32'h20);
    chk("t5_cnt5", bp.mispredict_cnt, 32'd5);
    chk("t5_sat_w2", {30'b0, bp2.mispredict_cnt}, 32'd3);
    idle();
    bp.upd_taken      = 1'b1;
    bp.upd_pred_taken = 1'b0;
    step();
    idle();
    chk("t5_noupd_cnt", bp.mispredict_cnt, 32'd5);
    chk("t5_nofetch_valid", {31'b0, bp.pred_valid}, 32'h0);
    chk("t5_nofetch_taken", {31'b0, bp.pred_taken}, 32'h0);
    chk("t5_nofetch_target", bp.pred_target, 32'h0);

    // 6: reset mid-stream drops the update; then BTB hit / alias
    idle();
    set_upd(32'h100, 1'b1, 1'b0, 32'h180);
    bp.fetch_req = 1'b1;
    bp.fetch_pc  = 32'h100;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("t6_rst_valid", {31'b0, bp.pred_valid}, 32'h0);
    chk("t6_rst_cnt", bp.mispredict_cnt, 32'h0);
    fetch(32'h100);
    chk("t6_drop_taken", {31'b0, bp.pred_taken}, 32'h0);
    chk("t6_drop_target", bp.pred_target, 32'h0);
    upd(32'h100, 1'b1, 1'b1, 32'h180);
    fetch(32'h100);
    chk("t6_hit_taken", {31'b0, bp.pred_taken}, 32'h1);
    chk("t6_hit_target", bp.pred_target, BTB ? 32'h180 : 32'h0);
    fetch(32'h100 + (32'd4 << 6));
    chk("t6_alias_taken", {31'b0, bp.pred_taken}, BTB ? 32'h0 : 32'h1);
    chk("t6_alias_target", bp.pred_target, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
